input_debouncer: RTL



---
 rtl/debounce_defs.sv | 16 +
 rtl/sync_chain.sv | 23 ++
 rtl/input_debouncer.sv | 113 +++++++++++
 3 files changed

// File: rtl/debounce_defs.sv
// Shared definitions for the input debouncer: FSM state encodings and counter sizing.
package debounce_defs;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b11,
    WAIT_LO   = 2'b10
  } deb_state_e;

  // Counter width able to hold 0 .. n-1 with one bit of headroom.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for one asynchronous bit; clears synchronously on reset.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q <= '0;
    end else begin
      s_q <= {s_q[STAGES-2:0], d};
    end
  end

  assign q = s_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous input into a clean level plus one-cycle rise/fall pulses.
module input_debouncer
  import debounce_defs::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = cnt_w(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic       ss;
  deb_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic dout_q, dout_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic busy_q, busy_d;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din),
    .q     (ss)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  // A reversal of ss always wins over acceptance, even on the last count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (ss) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!ss) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!ss) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (ss) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = STABLE_LO;
    endcase
    // busy tracks the registered state, so it is computed from the next state here.
    busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule
